// File: rtl/imm_ext_pipe.sv
// Mode-selectable immediate extender feeding a 2-entry elastic buffer with tag sideband and flush.
// Latency 1 cycle from push to out_*; no combinational path from in_* to out_*.
// in_ready = (count != 2); it is independent of out_ready; flush drops buffered items and any same-cycle push.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,  // must satisfy OUT_W >= IN_W + 2
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] imm_mem [2];
  logic [TAG_W-1:0] tag_mem [2];
  logic             err_mem [2];

  logic       head;
  logic       tail;
  logic [1:0] count;

  logic             push;
  logic             pop;
  logic             rd_idx;
  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_imm;
  logic             ext_err;

  // Extend the incoming immediate according to its mode; illegal modes fall back to ZERO and flag err.
  always_comb begin
    sign_ext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    ext_imm  = {{EXT_W{1'b0}}, in_imm};
    ext_err  = 1'b0;
    case (in_mode)
      3'b000:  ext_imm = {{EXT_W{1'b0}}, in_imm};
      3'b001:  ext_imm = sign_ext;
      3'b010:  ext_imm = {in_imm, {EXT_W{1'b0}}};
      3'b011:  ext_imm = {sign_ext[OUT_W-3:0], 2'b00};
      3'b100:  ext_imm = {{EXT_W{1'b1}}, in_imm};
      default: ext_err = 1'b1;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // An empty buffer presents entry 0 so outputs are deterministic (zero after reset).
  assign rd_idx  = out_valid ? head : 1'b0;
  assign out_imm = imm_mem[rd_idx];
  assign out_tag = tag_mem[rd_idx];
  assign out_err = err_mem[rd_idx];

  // Storage write: cleared only by reset; flush leaves contents in place and just blocks the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        imm_mem[i] <= '0;
        tag_mem[i] <= '0;
        err_mem[i] <= 1'b0;
      end
    end else if (push && !flush) begin
      imm_mem[tail] <= ext_imm;
      tag_mem[tail] <= in_tag;
      err_mem[tail] <= ext_err;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop and realigns pointers to entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

  typedef struct {
    logic [31:0] imm;
    logic [7:0]  tag;
    logic        err;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [7:0]  out_tag;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  item_t       q[$];
  logic [7:0]  pop_log[$];

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected extension computed arithmetically from the mode table.
  function automatic item_t model_item(input logic [15:0] imm, input logic [2:0] mode, input logic [7:0] tag);
    item_t it;
    int    s;
    s      = int'($signed(imm));
    it.tag = tag;
    it.err = 1'b0;
    case (mode)
      3'd0:    it.imm = 32'(imm);
      3'd1:    it.imm = 32'(s);
      3'd2:    it.imm = 32'(imm) * 32'd65536;
      3'd3:    it.imm = 32'(s * 4);
      3'd4:    it.imm = 32'hFFFF_0000 | 32'(imm);
      default: begin it.imm = 32'(imm); it.err = 1'b1; end
    endcase
    return it;
  endfunction

  // Reference queue: a 2-deep FIFO of expected items updated at each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) begin
          pop_log.push_back(q[0].tag);
          void'(q.pop_front());
        end
        if (do_push) q.push_back(model_item(in_imm, in_mode, in_tag));
      end
    end
  end

  // Compare DUT against the reference on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(q.size() != 2));
      if (q.size() != 0) begin
        check("out_imm", out_imm, q[0].imm);
        check("out_tag", 32'(out_tag), 32'(q[0].tag));
        check("out_err", 32'(out_err), 32'(q[0].err));
      end
    end
  end

  // Present one item and hold it until accepted; returns 2 time units after the accepting edge.
  task automatic send(input logic [15:0] imm, input logic [2:0] mode, input logic [7:0] tag);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 20);
    check("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bit acc;
    int n;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Mode table with hand-computed results, visible right after the accepting edge.
    send(16'h8004, 3'b001, 8'h01); check("lit_sign", out_imm, 32'hFFFF_8004);
    send(16'h8004, 3'b000, 8'h02); check("lit_zero", out_imm, 32'h0000_8004);
    send(16'h1234, 3'b010, 8'h03); check("lit_upper", out_imm, 32'h1234_0000);
    send(16'hFFFF, 3'b011, 8'h04); check("lit_branch_neg", out_imm, 32'hFFFF_FFFC);
    send(16'h0010, 3'b011, 8'h05); check("lit_branch_pos", out_imm, 32'h0000_0040);
    send(16'h0001, 3'b100, 8'h06); check("lit_ones", out_imm, 32'hFFFF_0001);
    send(16'hABCD, 3'b110, 8'h5A);
    check("lit_illegal_imm", out_imm, 32'h0000_ABCD);
    check("lit_illegal_err", 32'(out_err), 32'd1);
    check("lit_illegal_tag", 32'(out_tag), 32'h5A);
    send(16'h7FFF, 3'b101, 8'h07);
    send(16'h7FFF, 3'b111, 8'h08);
    send(16'h8000, 3'b011, 8'h09); check("lit_branch_min", out_imm, 32'hFFFE_0000);
    idle(3);

    // Backpressure: two items fill the buffer, the third stalls until the consumer resumes.
    out_ready = 1'b0;
    pop_log.delete();
    send(16'h0011, 3'b000, 8'd1);
    send(16'h0022, 3'b001, 8'd2);
    in_valid = 1'b1; in_imm = 16'h0033; in_mode = 3'b010; in_tag = 8'd3;
    idle(3);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_head_held", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 20);
    check("bp_tag3_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    idle(4);
    check("bp_pop_count", 32'(pop_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < pop_log.size(); i++)
      check("bp_order", 32'(pop_log[i]), 32'(i + 1));

    // Streaming at count==1: simultaneous push and pop every cycle.
    pop_log.delete();
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_imm = 16'(i * 16'h0101); in_mode = 3'b001; in_tag = 8'(8'h20 + i);
      @(negedge clk);
      if (i > 0) begin
        check("stream_in_ready", 32'(in_ready), 32'd1);
        check("stream_out_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    idle(3);
    check("stream_pop_count", 32'(pop_log.size()), 32'd11);
    for (int i = 0; i < 11 && i < pop_log.size(); i++)
      check("stream_order", 32'(pop_log[i]), 32'(8'h20 + i));

    // Flush with a full buffer and a concurrent push.
    out_ready = 1'b0;
    send(16'h0AAA, 3'b000, 8'h30);
    send(16'h0BBB, 3'b000, 8'h31);
    flush = 1'b1;
    in_valid = 1'b1; in_imm = 16'h0CCC; in_mode = 3'b000; in_tag = 8'h77;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    idle(1);
    check("flush_stays_empty", 32'(out_valid), 32'd0);
    send(16'h1111, 3'b010, 8'h40);
    check("post_flush_head", 32'(out_tag), 32'h40);
    send(16'h2222, 3'b001, 8'h41);

    // Asynchronous reset mid-stream discards everything immediately.
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_imm", out_imm, 32'd0);
    check("arst_out_tag", 32'(out_tag), 32'd0);
    check("arst_out_err", 32'(out_err), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h0F0F; in_mode = 3'b000; in_tag = 8'h99;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("first_push_valid", 32'(out_valid), 32'd1);
    check("first_push_tag", 32'(out_tag), 32'h99);
    check("first_push_imm", out_imm, 32'h0000_0F0F);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
